// File: rtl/rst_seq_pkg.sv
// Shared definitions for the ordered reset-release sequencer:
// FSM state encoding and the stage-index width helper.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_ASSERT  = 2'd3
  } seq_state_t;

  // Width of an index over n items, never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Shared delay counter: counts enabled cycles and flags the cycle whose
// count equals the terminal value, then restarts from zero.
module rst_seq_timer #(
  parameter int DELAY_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               enable,
  input  logic [DELAY_W-1:0] terminal,
  output logic               done
);

  logic [DELAY_W-1:0] cnt_r;
  logic               done_s;

  assign done_s = enable && (cnt_r == terminal);
  assign done   = done_s;

  // Counter: restarts on clear or at terminal count, otherwise advances when enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {DELAY_W{1'b0}};
    end else if (clear || done_s) begin
      cnt_r <= {DELAY_W{1'b0}};
    end else if (enable) begin
      cnt_r <= cnt_r + {{(DELAY_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/rst_sequencer.sv
// Ordered reset-release controller: holds all domains in reset, releases them
// one by one, then serves soft-reset requests over a 4-phase req/ack handshake.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int NUM_REQ     = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_DELAY = 1000,
  parameter int DELAY_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    soft_req,
  output logic [NUM_REQ-1:0]    soft_ack,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  sys_ready,
  output logic                  busy,
  output logic [NUM_REQ-1:0]    cause
);

  localparam int IDX_W = idx_width(NUM_STAGES);

  seq_state_t            state_r;
  logic [IDX_W-1:0]      idx_r;
  logic [NUM_REQ-1:0]    pending_r;
  logic [NUM_REQ-1:0]    mask_r;
  logic [NUM_REQ-1:0]    soft_ack_r;
  logic [NUM_STAGES-1:0] stage_rst_r;
  logic                  sys_ready_r;
  logic                  busy_r;
  logic [NUM_REQ-1:0]    cause_r;

  logic                  tmr_clear_s;
  logic                  tmr_enable_s;
  logic [DELAY_W-1:0]    tmr_term_s;
  logic                  tmr_done_s;
  logic [NUM_REQ-1:0]    eligible_s;
  logic                  last_stage_s;

  assign eligible_s   = soft_req & ~mask_r;
  assign last_stage_s = (idx_r == IDX_W'(NUM_STAGES - 1));

  rst_seq_timer #(.DELAY_W(DELAY_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (tmr_clear_s),
    .enable   (tmr_enable_s),
    .terminal (tmr_term_s),
    .done     (tmr_done_s)
  );

  // Timer runs only in HOLD and RELEASE, with a per-state terminal count.
  always_comb begin
    tmr_clear_s  = 1'b1;
    tmr_enable_s = 1'b0;
    tmr_term_s   = DELAY_W'(STAGE_DELAY - 1);
    case (state_r)
      ST_HOLD: begin
        tmr_clear_s  = 1'b0;
        tmr_enable_s = 1'b1;
        tmr_term_s   = DELAY_W'(HOLD_CYCLES - 1);
      end
      ST_RELEASE: begin
        tmr_clear_s  = 1'b0;
        tmr_enable_s = 1'b1;
      end
      default: begin
        tmr_clear_s  = 1'b1;
        tmr_enable_s = 1'b0;
      end
    endcase
  end

  // Sequencer FSM with handshake bookkeeping and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_HOLD;
      idx_r       <= {IDX_W{1'b0}};
      pending_r   <= {NUM_REQ{1'b0}};
      mask_r      <= {NUM_REQ{1'b0}};
      soft_ack_r  <= {NUM_REQ{1'b0}};
      stage_rst_r <= {NUM_STAGES{1'b1}};
      sys_ready_r <= 1'b0;
      busy_r      <= 1'b1;
      cause_r     <= {NUM_REQ{1'b0}};
    end else begin
      soft_ack_r <= {NUM_REQ{1'b0}};
      case (state_r)
        ST_HOLD: begin
          if (tmr_done_s) begin
            state_r <= ST_RELEASE;
            idx_r   <= {IDX_W{1'b0}};
          end
        end
        ST_RELEASE: begin
          if (tmr_done_s) begin
            stage_rst_r[idx_r] <= 1'b0;
            if (last_stage_s) begin
              state_r     <= ST_RUN;
              sys_ready_r <= 1'b1;
              busy_r      <= 1'b0;
              soft_ack_r  <= pending_r;
              mask_r      <= mask_r | pending_r;
              pending_r   <= {NUM_REQ{1'b0}};
            end else begin
              idx_r <= idx_r + IDX_W'(1);
            end
          end
        end
        ST_RUN: begin
          // A request still high after its ack stays masked until seen low.
          mask_r <= mask_r & soft_req;
          if (eligible_s != {NUM_REQ{1'b0}}) begin
            pending_r   <= eligible_s;
            cause_r     <= eligible_s;
            state_r     <= ST_ASSERT;
            stage_rst_r <= {NUM_STAGES{1'b1}};
            sys_ready_r <= 1'b0;
            busy_r      <= 1'b1;
          end
        end
        ST_ASSERT: begin
          state_r <= ST_HOLD;
        end
        default: begin
          state_r <= ST_HOLD;
        end
      endcase
    end
  end

  assign soft_ack  = soft_ack_r;
  assign stage_rst = stage_rst_r;
  assign sys_ready = sys_ready_r;
  assign busy      = busy_r;
  assign cause     = cause_r;

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer: timing of every release sequence is
// checked edge by edge; acknowledges are matched against a queue of expected acks.
module tb_rst_sequencer;

  localparam int NS      = 3;
  localparam int NR      = 2;
  localparam int H       = 4;
  localparam int D       = 8;
  localparam int DW      = 16;
  localparam int SEQ_LEN = H + NS * D;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] soft_req = '0;
  logic [NR-1:0] soft_ack;
  logic [NS-1:0] stage_rst;
  logic          sys_ready;
  logic          busy;
  logic [NR-1:0] cause;

  int checks = 0;
  int errors = 0;
  logic [NR-1:0] ack_q[$];

  rst_sequencer #(
    .NUM_STAGES  (NS),
    .NUM_REQ     (NR),
    .HOLD_CYCLES (H),
    .STAGE_DELAY (D),
    .DELAY_W     (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .soft_req  (soft_req),
    .soft_ack  (soft_ack),
    .stage_rst (stage_rst),
    .sys_ready (sys_ready),
    .busy      (busy),
    .cause     (cause)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Stage i is released H + (i+1)*D edges after the reference edge.
  function automatic logic [NS-1:0] exp_stage(input int k);
    logic [NS-1:0] r;
    for (int i = 0; i < NS; i++) r[i] = (k < H + (i + 1) * D);
    return r;
  endfunction

  // Scoreboard: every ack pulse must match the next expected entry.
  always @(negedge clk) begin
    if (!rst && soft_ack != '0) begin
      if (ack_q.size() == 0) begin
        check_val("ack_unexpected", soft_ack, 0);
      end else begin
        check_val("ack", soft_ack, ack_q.pop_front());
      end
    end
  end

  task automatic run_release(input string tag, input logic [NR-1:0] cause_exp,
                             input logic [NR-1:0] mid_req, input int mid_k);
    for (int k = 1; k <= SEQ_LEN; k++) begin
      @(posedge clk); #1;
      check_val({tag, "_stage"}, stage_rst, exp_stage(k));
      if (k >= SEQ_LEN - 1) begin
        check_val({tag, "_ready"}, sys_ready, (k == SEQ_LEN) ? 1 : 0);
        check_val({tag, "_busy"}, busy, (k == SEQ_LEN) ? 0 : 1);
      end
      if (k == mid_k && mid_req != '0) begin
        soft_req = soft_req | mid_req;
        ack_q.push_back(mid_req);
      end
    end
    check_val({tag, "_cause"}, cause, cause_exp);
  endtask

  // Expects the request to be eligible at the next edge (RUN -> ASSERT).
  task automatic soft_seq(input string tag, input logic [NR-1:0] cause_exp,
                          input logic [NR-1:0] mid_req, input int mid_k);
    @(posedge clk); #1;
    check_val({tag, "_assert_stage"}, stage_rst, 3'b111);
    check_val({tag, "_assert_ready"}, sys_ready, 0);
    check_val({tag, "_assert_busy"}, busy, 1);
    check_val({tag, "_assert_cause"}, cause, cause_exp);
    @(posedge clk); #1;
    check_val({tag, "_hold_stage"}, stage_rst, 3'b111);
    run_release(tag, cause_exp, mid_req, mid_k);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check_val("idle_stage", stage_rst, 0);
      check_val("idle_busy", busy, 0);
    end
  endtask

  initial begin
    repeat (5) @(posedge clk);
    #1;
    check_val("rst_stage", stage_rst, 3'b111);
    check_val("rst_ack", soft_ack, 0);
    check_val("rst_ready", sys_ready, 0);
    check_val("rst_busy", busy, 1);
    check_val("rst_cause", cause, 0);
    rst = 1'b0;
    run_release("por", 2'b00, 2'b00, 0);
    idle(2);

    soft_req = 2'b10; ack_q.push_back(2'b10);
    soft_seq("s10", 2'b10, 2'b00, 0);
    soft_req = 2'b00;
    idle(2);

    soft_req = 2'b11; ack_q.push_back(2'b11);
    soft_seq("s11", 2'b11, 2'b00, 0);
    soft_req = 2'b01;
    idle(50);
    soft_req = 2'b00;
    @(posedge clk); #1;
    soft_req = 2'b01; ack_q.push_back(2'b01);
    soft_seq("s01", 2'b01, 2'b00, 0);
    soft_req = 2'b00;
    idle(2);

    soft_req = 2'b01; ack_q.push_back(2'b01);
    soft_seq("sa", 2'b01, 2'b10, 10);
    soft_req = 2'b10;
    soft_seq("sb", 2'b10, 2'b00, 0);
    soft_req = 2'b00;
    idle(2);

    // Reset in the middle of RELEASE, after stage 0 has been released.
    soft_req = 2'b01;
    @(posedge clk);
    @(posedge clk);
    repeat (H + D + 3) @(posedge clk);
    #1;
    check_val("mid_stage", stage_rst, 3'b110);
    rst = 1'b1;
    #1;
    check_val("mid_rst_stage", stage_rst, 3'b111);
    check_val("mid_rst_busy", busy, 1);
    check_val("mid_rst_ready", sys_ready, 0);
    check_val("mid_rst_cause", cause, 0);
    check_val("mid_rst_ack", soft_ack, 0);
    soft_req = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    run_release("por2", 2'b00, 2'b00, 0);
    idle(3);

    check_val("ack_q_empty", ack_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Ordered reset-release controller placed directly after the board clock/reset generator.
- Takes its synchronised system reset and releases NUM_STAGES downstream reset domains one at a time, in index order, with a programmable gap between releases (e.g. flash interface first, then CPU, then peripherals).
- Also serves soft-reset requests from NUM_REQ requesters over a 4-phase req/ack handshake. Each request re-runs the full assert/release sequence.
- Records which requesters caused the last soft reset.

Parameters:
- NUM_STAGES, 4: number of reset domains; must be >= 1.
- NUM_REQ, 2: number of soft-reset requesters; must be >= 1.
- HOLD_CYCLES, 16: cycles all stages stay asserted before release starts; must be >= 1.
- STAGE_DELAY, 1000: cycles between successive stage releases; must be >= 1.
- DELAY_W, 16: counter width; must hold max(HOLD_CYCLES, STAGE_DELAY)-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- soft_req  in  NUM_REQ  level soft-reset requests, one bit per requester.
- soft_ack  out  NUM_REQ  one-cycle acknowledge pulse per served requester.
- stage_rst  out  NUM_STAGES  active-high reset per domain; bit 0 is released first.
- sys_ready  out  1  high when all stages are released and the block is idle.
- busy  out  1  high while a sequence is in progress.
- cause  out  NUM_REQ  requesters served by the most recent soft reset.

Behaviour:
- Reset values (while rst=1, applied asynchronously):
  - stage_rst = all ones; soft_ack = 0; sys_ready = 0; busy = 1; cause = 0.
  - Internal state: state = HOLD, counter = 0, stage index = 0, pending = 0, mask = 0.
- All outputs are registered. Cycle numbering: edge 1 is the first clk rising edge after rst falls.
- HOLD state:
  - All stage_rst bits stay asserted.
  - The counter counts HOLD_CYCLES cycles (edges 1..H); at edge H it clears and the state moves to RELEASE with index = 0.
- RELEASE state:
  - The counter runs 0..STAGE_DELAY-1.
  - On the edge where counter = STAGE_DELAY-1: clear stage_rst[index], increment index, clear counter.
  - Result: stage_rst[i] falls at edge H + (i+1)*D; already-released bits stay low.
  - On the edge that releases bit NUM_STAGES-1, in the same edge:
    - state moves to RUN; sys_ready goes to 1; busy goes to 0;
    - soft_ack is driven with pending for one cycle;
    - mask |= pending; pending is cleared.
- RUN state:
  - Each cycle, mask bits are cleared where soft_req is 0.
  - eligible = soft_req & ~mask. If eligible is non-zero, on the next edge:
    - pending = eligible; cause = eligible; state moves to ASSERT;
    - stage_rst goes to all ones; sys_ready goes to 0; busy goes to 1.
  - All simultaneously eligible requesters are served by one sequence.
- ASSERT state: one cycle, then moves to HOLD with counter = 0. Timing from then on is identical to power-on.
- Handshake rules:
  - A requester holds req high until it sees ack.
  - A req still high after ack is masked and never retriggers. The bit must be observed low in RUN before it can trigger again.
  - A req raised while busy is not sampled. Once RUN is reached it triggers a new sequence, and is not added to the current sequence's pending or ack.
- rst asserted mid-sequence or in RUN:
  - Immediately returns every output and all internal state to the reset values; no ack is issued.
  - cause is cleared to 0 (cause is cleared only by rst).
- Counter arithmetic is unsigned DELAY_W-bit and never wraps, because DELAY_W is sized to the largest terminal count.
- NUM_STAGES = 1: RELEASE releases the single bit and enters RUN after one STAGE_DELAY.

Decomposition:
- Shared include/package rst_seq_pkg:
  - state encoding constants: HOLD, RELEASE, RUN, ASSERT (2-bit);
  - the index-width helper (clog2 of NUM_STAGES).
- One sub-module, rst_seq_timer: loadable DELAY_W up-counter.
  - Inputs: clear, enable, terminal count.
  - Output: single-cycle done flag.
  - Instantiated once and shared by HOLD and RELEASE.
- The FSM, mask/pending/cause registers and output registers live in rst_sequencer.

Test Plan (bench parameters: NUM_STAGES=3, NUM_REQ=2, HOLD_CYCLES=4, STAGE_DELAY=8):
- Power-on: hold rst=1 for 5 cycles, then drop it -> stage_rst=111 through edge 4; bit0 falls at edge 12, bit1 at edge 20, bit2 at edge 28; sys_ready=1 and busy=0 from edge 28; cause=00; soft_ack=00 throughout.
- In RUN, raise soft_req=10 -> next edge: stage_rst=111, sys_ready=0, cause=10; the release sequence repeats with the same offsets counted from the ASSERT->HOLD edge; soft_ack=10 for exactly one cycle at RUN entry.
- Raise soft_req=11 in the same cycle -> exactly one sequence; soft_ack=11 pulses once; cause=11.
- Keep soft_req[0] high for 50 cycles after its ack -> no new sequence. Drop it for 1 cycle and raise it again -> a new sequence starts; cause=01.
- Raise soft_req[0] in RUN, then raise soft_req[1] during the resulting RELEASE -> first ack=01; second sequence begins the cycle after RUN entry; second ack=10; cause=10.
- Assert rst mid-RELEASE (stage_rst=110) -> stage_rst=111, busy=1, cause=00 without waiting for a clk edge; pending is dropped and no soft_ack is issued; after rst falls the full power-on timing is observed.
